psum_col_fifo: RTL
==================

Name: psum_col_fifo

Overview:
- Downstream of the MAC array: collects the per-column partial sums presented on the array's south edge.
- Each column's psum is written into that column's own FIFO only when the column's valid bit is high. Columns arrive skewed in time, so each FIFO has independent write timing.
- A single read pops one aligned word from every column at once, giving a full output row (all columns) to the accumulation/SFU stage.
- Sticky error flags record overflow and illegal reads.

Parameters:
- psum_bw, 16, bit width of one column's partial sum.
- col, 8, number of columns, i.e. number of independent FIFOs.
- depth, 16, entries per column FIFO. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  psum_bw*col  column psums; column c occupies bits [c*psum_bw +: psum_bw].
- wr  input  col  per-column write strobe (the array's valid bits).
- rd  input  1  request to pop one full row.
- out  output  psum_bw*col  registered popped row, same column packing as in.
- out_valid  output  1  high for one cycle when out carries a freshly popped row.
- o_ready  output  1  every column FIFO is non-empty, so a row is available.
- o_full  output  1  at least one column FIFO is full.
- o_empty  output  1  every column FIFO is empty.
- overflow  output  1  sticky: a write arrived at a full column.
- underrun  output  1  sticky: rd was asserted while o_ready was low.

Behaviour:
- Reset (reset=0, asynchronous):
  - all write pointers, the read pointer and all counts clear to 0;
  - out=0, out_valid=0, overflow=0, underrun=0;
  - so o_ready=0, o_full=0, o_empty=1.
  - Reset mid-stream discards all stored data. No partial row is emitted after reset releases.
- Storage: per column c, a memory of depth×psum_bw, a write pointer wp[c], and a count cnt[c] of width clog2(depth)+1.
- Read pointer: one shared pointer rp, valid because every pop removes exactly one entry from every column.
- Write, column c: if wr[c]=1 and cnt[c]<depth, then mem[c][wp[c]] <= in slice c and wp[c] increments, wrapping modulo depth.
- Write to a full column: if wr[c]=1 and cnt[c]=depth, the write is dropped, storage and pointers are unchanged, and overflow is set.
- Pop: a pop is accepted when rd=1 and o_ready=1. On that edge:
  - out <= {mem[col-1][rp], …, mem[0][rp]};
  - rp increments, wrapping modulo depth;
  - every cnt[c] decrements.
- Read latency: out and out_valid update on the edge where rd is sampled (1-cycle latency). out_valid is high for exactly one cycle per accepted pop. out holds its value until the next accepted pop.
- rd with o_ready=0: no pop, out unchanged, out_valid=0 next cycle, underrun is set.
- Write and pop on the same edge, same column:
  - both take effect and cnt[c] is unchanged;
  - the write is accepted even if cnt[c]=depth, because the pop frees a slot in the same edge;
  - read data is the old head entry, never the word being written.
- Back-to-back: rd held high with o_ready continuously high pops one row per cycle.
- Status outputs are combinational from the counts:
  - o_ready = AND over c of (cnt[c]≠0);
  - o_full = OR over c of (cnt[c]=depth);
  - o_empty = AND over c of (cnt[c]=0).
- Sticky flags: overflow and underrun clear only on reset.
- Arithmetic: data is stored and output unmodified. No sign extension or truncation.

Test Plan:
- Fill and drain:
  - Stimulus: after reset, assert wr=8'hFF for 4 cycles with column c = 16'h0100*c + k on cycle k (k=0..3), then hold rd=1 for 4 cycles.
  - Required: o_ready rises after the first write edge; 4 consecutive out_valid pulses; row k has column c = 16'h0100*c + k; o_empty=1 afterwards.
- Skewed arrival:
  - Stimulus: wr bit c asserted for one cycle at cycle c (c=0..7), data 16'hA000+c.
  - Required: o_ready stays 0 until cycle 7's write edge, then 1; a single pop returns 16'hA000+c in column c.
- Overflow and simultaneous pop:
  - Stimulus: write column 0 with 17 values (16'd1..16'd17) while the other columns stay empty.
  - Required: o_full=1 after 16 writes; the 17th write is dropped and overflow=1.
  - Stimulus: then fill the other columns, and on one edge assert rd together with wr[0] carrying 16'hBEEF.
  - Required: the pop returns 16'd1 in column 0; cnt[0] stays 16; the next 15 pops return 16'd2..16'd16; the 16th returns 16'hBEEF.
- Underrun:
  - Stimulus: rd=1 with only column 3 holding data.
  - Required: out_valid=0, out unchanged, underrun=1, column 3's data is retained.
- Pointer wrap:
  - Stimulus: 40 rows streamed with simultaneous write and pop each cycle after a 1-row prefill, data = row index.
  - Required: rows out in order 0..39, no flags set.
- Reset mid-operation:
  - Stimulus: 5 rows stored, then reset pulsed low for a half cycle asynchronously.
  - Required: outputs clear immediately; o_empty=1; no out_valid after release until new writes arrive.

Source files
------------

// File: rtl/psum_col_fifo.sv
// psum_col_fifo
// Collects the skewed per-column partial sums leaving the south edge of the
// MAC array. Every column owns an independent FIFO with its own write timing;
// a single read pops one aligned entry from every column, producing a full
// output row for the accumulation / SFU stage. Sticky flags record writes
// into a full column and reads issued while no full row was available.

module psum_col_fifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   overflow,
  output logic                   underrun
);

  // Pointer width addresses one entry; count width also represents "depth".
  localparam int aw = (depth > 2) ? $clog2(depth) : 1;
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] cnt_full = cw'(depth);

  // Shared read pointer: every pop removes one entry from every column, so a
  // single pointer stays aligned with all column heads.
  logic [aw-1:0] rp_reg;
  logic [aw-1:0] rp_next;
  logic          out_valid_reg;
  logic          overflow_reg;
  logic          overflow_next;
  logic          underrun_reg;
  logic          underrun_next;

  // Per-column status and event vectors, each bit driven by its own column.
  logic [col-1:0] nonempty_vec;
  logic [col-1:0] full_vec;
  logic [col-1:0] drop_vec;

  // Popped row, one register per column.
  logic [psum_bw-1:0] out_col_reg [col];

  logic pop;

  // A pop needs a head entry in every column.
  assign pop = rd & o_ready;

  // Status is purely combinational from the per-column counts.
  assign o_ready = &nonempty_vec;
  assign o_full  = |full_vec;
  assign o_empty = ~|nonempty_vec;

  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;
  assign underrun  = underrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_col
      logic [psum_bw-1:0] mem [depth];
      logic [aw-1:0]      wp_reg;
      logic [aw-1:0]      wp_next;
      logic [cw-1:0]      cnt_reg;
      logic [cw-1:0]      cnt_next;
      logic               col_full;
      logic               wr_ok;

      assign col_full          = (cnt_reg == cnt_full);
      assign full_vec[gi]      = col_full;
      assign nonempty_vec[gi]  = (cnt_reg != '0);
      // A full column can still accept a write on an edge that also pops,
      // because the pop frees the head slot on that same edge.
      assign wr_ok             = wr[gi] & (~col_full | pop);
      assign drop_vec[gi]      = wr[gi] & col_full & ~pop;
      assign out[gi*psum_bw +: psum_bw] = out_col_reg[gi];

      // Next write pointer and occupancy; a simultaneous write and pop
      // leaves the count unchanged.
      always_comb begin
        wp_next  = wp_reg;
        cnt_next = cnt_reg;
        if (wr_ok) begin
          wp_next = wp_reg + aw'(1);
        end
        if (wr_ok && !pop) begin
          cnt_next = cnt_reg + cw'(1);
        end else if (!wr_ok && pop) begin
          cnt_next = cnt_reg - cw'(1);
        end
      end

      // Storage array: no reset so it maps onto block RAM; stale contents
      // are unreachable once the pointers and count are cleared.
      always_ff @(posedge clk) begin
        if (wr_ok) begin
          mem[wp_reg] <= in[gi*psum_bw +: psum_bw];
        end
      end

      // Column pointer and count registers.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wp_reg  <= '0;
          cnt_reg <= '0;
        end else begin
          wp_reg  <= wp_next;
          cnt_reg <= cnt_next;
        end
      end

      // Registered read of the head entry; the old head is returned even when
      // the same edge writes into this column.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_col_reg[gi] <= '0;
        end else if (pop) begin
          out_col_reg[gi] <= mem[rp_reg];
        end
      end
    end
  endgenerate

  // Next read pointer and sticky error flags.
  always_comb begin
    rp_next       = rp_reg;
    overflow_next = overflow_reg;
    underrun_next = underrun_reg;
    if (pop) begin
      rp_next = rp_reg + aw'(1);
    end
    if (|drop_vec) begin
      overflow_next = 1'b1;
    end
    if (rd && !o_ready) begin
      underrun_next = 1'b1;
    end
  end

  // Shared read-side state: pointer, one-cycle valid pulse, sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp_reg        <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      rp_reg        <= rp_next;
      out_valid_reg <= pop;
      overflow_reg  <= overflow_next;
      underrun_reg  <= underrun_next;
    end
  end

endmodule
